idli_sqi_mem_m: RTL

Parametrised, synthesisable SQI serial-RAM model: the next-generation memory attachment for the idli bench, which replaces script-driven memory pins with an RTL device. One instance connects to each SQI channel, low and high. It decodes the SQI command/address/dummy/data protocol sampled in the gck domain, and serves sequential reads and writes to an internal byte array with address auto-increment and wrap. A backdoor port lets the bench preload and inspect contents.

---
 rtl/idli_pkg.sv | 23 ++
 rtl/idli_sqi_edge_m.sv | 30 +++
 rtl/idli_sqi_mem_m.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli bench devices.
//   slice_t          - one 4-bit SQI nibble as it appears on the sio pins.
//   SQI_CMD_READ     - serial-RAM sequential read command byte.
//   SQI_CMD_WRITE    - serial-RAM sequential write command byte.
//   sqi_mem_state_t  - protocol states of the SQI serial-RAM model.
package idli_pkg;

  typedef logic [3:0] slice_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    SQI_IDLE    = 3'd0,
    SQI_CMD     = 3'd1,
    SQI_ADDR    = 3'd2,
    SQI_DUMMY   = 3'd3,
    SQI_READ    = 3'd4,
    SQI_WRITE   = 3'd5,
    SQI_DISCARD = 3'd6
  } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_edge_m.sv
// idli_sqi_edge_m: registers the serial clock and flags its edges in the
// system clock domain. Shared by the SQI bench devices.
//   clk  in  system clock (gck), rising edge
//   rst  in  synchronous active-high reset
//   sck  in  serial clock, synchronous to clk
//   rise out sck is high now and was low last cycle
//   fall out sck is low now and was high last cycle
module idli_sqi_edge_m (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  output logic rise,
  output logic fall
);

  logic sck_q_r;

  // Previous-cycle copy of the serial clock
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q_r <= 1'b0;
    end else begin
      sck_q_r <= sck;
    end
  end

  assign rise = sck & ~sck_q_r;
  assign fall = ~sck & sck_q_r;

endmodule

// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI serial-RAM model. Decodes command, address, dummy and
// data nibbles sampled on gck and serves sequential reads/writes to an
// internal byte array with auto-increment and wrap.
//   i_sqi_gck      in  clock, rising edge
//   i_sqi_rst      in  synchronous active-high reset
//   i_sqi_sck      in  serial clock (synchronous to gck)
//   i_sqi_cs_n     in  chip select, active-low
//   i_sqi_sio      in  nibble from core
//   o_sqi_sio      out nibble to core (registered)
//   o_sqi_oe       out high while read data is driven (registered)
//   i_sqi_bd_we    in  backdoor byte write enable
//   i_sqi_bd_addr  in  backdoor address
//   i_sqi_bd_data  in  backdoor write data
//   o_sqi_bd_data  out asynchronous array read at i_sqi_bd_addr
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W        = 17,
  parameter int ADDR_NIBBLES  = 6,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst,
  input  logic              i_sqi_sck,
  input  logic              i_sqi_cs_n,
  input  slice_t            i_sqi_sio,
  output slice_t            o_sqi_sio,
  output logic              o_sqi_oe,
  input  logic              i_sqi_bd_we,
  input  logic [ADDR_W-1:0] i_sqi_bd_addr,
  input  logic [7:0]        i_sqi_bd_data,
  output logic [7:0]        o_sqi_bd_data
);

  localparam int CNT_MAX    = (ADDR_NIBBLES > 2) ? ADDR_NIBBLES : 2;
  localparam int CNT_W      = $clog2(CNT_MAX);
  localparam int DUMMY_LAST = (DUMMY_NIBBLES > 0) ? DUMMY_NIBBLES - 1 : 0;

  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  ADDR_END   = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0]  DUMMY_END  = CNT_W'(DUMMY_LAST);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  sqi_mem_state_t    state_r, next_state_s;
  logic              rise_s, fall_s;
  logic              armed_r;     // cs_n seen high since reset
  logic [CNT_W-1:0]  cnt_r;
  logic              half_r;      // 1 = low nibble of current byte is next
  slice_t            cmd_hi_r;
  slice_t            wr_hi_r;
  logic              is_write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        cmd_byte_s;
  logic              sqi_we_s;
  logic [7:0]        mem_r [2**ADDR_W];

  idli_sqi_edge_m u_edge (
    .clk  (i_sqi_gck),
    .rst  (i_sqi_rst),
    .sck  (i_sqi_sck),
    .rise (rise_s),
    .fall (fall_s)
  );

  assign cmd_byte_s    = {cmd_hi_r, i_sqi_sio};
  assign o_sqi_bd_data = mem_r[i_sqi_bd_addr];

  // Next-state decode and SQI write strobe
  always_comb begin
    next_state_s = state_r;
    sqi_we_s     = 1'b0;
    if (i_sqi_cs_n) begin
      next_state_s = SQI_IDLE;
    end else begin
      case (state_r)
        SQI_IDLE: begin
          // After reset a fresh cs_n high->low is needed to start again
          if (armed_r) next_state_s = SQI_CMD;
          else         next_state_s = SQI_IDLE;
        end
        SQI_CMD: begin
          if (rise_s && (cnt_r != {CNT_W{1'b0}})) begin
            if ((cmd_byte_s == SQI_CMD_READ) || (cmd_byte_s == SQI_CMD_WRITE))
              next_state_s = SQI_ADDR;
            else
              next_state_s = SQI_DISCARD;
          end else begin
            next_state_s = SQI_CMD;
          end
        end
        SQI_ADDR: begin
          if (rise_s && (cnt_r == ADDR_END)) begin
            if (is_write_r)              next_state_s = SQI_WRITE;
            else if (DUMMY_NIBBLES == 0) next_state_s = SQI_READ;
            else                         next_state_s = SQI_DUMMY;
          end else begin
            next_state_s = SQI_ADDR;
          end
        end
        SQI_DUMMY: begin
          if (rise_s && (cnt_r == DUMMY_END)) next_state_s = SQI_READ;
          else                                next_state_s = SQI_DUMMY;
        end
        SQI_WRITE: begin
          next_state_s = SQI_WRITE;
          sqi_we_s     = rise_s & half_r & ~i_sqi_rst;
        end
        SQI_READ:    next_state_s = SQI_READ;
        SQI_DISCARD: next_state_s = SQI_DISCARD;
        default:     next_state_s = SQI_IDLE;
      endcase
    end
  end

  // State register and per-state datapath (counters, address, read data)
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_r    <= SQI_IDLE;
      armed_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      half_r     <= 1'b0;
      cmd_hi_r   <= 4'h0;
      wr_hi_r    <= 4'h0;
      is_write_r <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      o_sqi_sio  <= 4'h0;
      o_sqi_oe   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (i_sqi_cs_n) begin
        armed_r   <= 1'b1;
        cnt_r     <= {CNT_W{1'b0}};
        half_r    <= 1'b0;
        o_sqi_sio <= 4'h0;
        o_sqi_oe  <= 1'b0;
      end else begin
        case (state_r)
          SQI_CMD: begin
            if (rise_s) begin
              if (cnt_r == {CNT_W{1'b0}}) begin
                cmd_hi_r <= i_sqi_sio;
                cnt_r    <= CNT_ONE;
              end else begin
                cnt_r      <= {CNT_W{1'b0}};
                is_write_r <= (cmd_byte_s == SQI_CMD_WRITE);
              end
            end
          end
          SQI_ADDR: begin
            if (rise_s) begin
              // Shift in MSB first; bits above ADDR_W fall off the top
              addr_r <= ADDR_W'({addr_r, i_sqi_sio});
              if (cnt_r == ADDR_END) cnt_r <= {CNT_W{1'b0}};
              else                   cnt_r <= cnt_r + CNT_ONE;
            end
          end
          SQI_DUMMY: begin
            if (rise_s) begin
              if (cnt_r == DUMMY_END) cnt_r <= {CNT_W{1'b0}};
              else                    cnt_r <= cnt_r + CNT_ONE;
            end
          end
          SQI_READ: begin
            if (fall_s) begin
              o_sqi_oe <= 1'b1;
              half_r   <= ~half_r;
              if (half_r) begin
                o_sqi_sio <= mem_r[addr_r][3:0];
                addr_r    <= addr_r + ADDR_ONE;
              end else begin
                o_sqi_sio <= mem_r[addr_r][7:4];
              end
            end
          end
          SQI_WRITE: begin
            if (rise_s) begin
              half_r <= ~half_r;
              if (half_r) addr_r  <= addr_r + ADDR_ONE;
              else        wr_hi_r <= i_sqi_sio;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Byte array: backdoor write is issued last so it wins on an address clash
  always_ff @(posedge i_sqi_gck) begin
    if (sqi_we_s) mem_r[addr_r] <= {wr_hi_r, i_sqi_sio};
    if (i_sqi_bd_we) mem_r[i_sqi_bd_addr] <= i_sqi_bd_data;
  end

endmodule
